ntt_bf_writeback: RTL and testbench
===================================

// Module: ntt_bf_writeback
// PURPOSE
// - Downstream stage of the Cooley-Tukey butterfly unit. Captures the butterfly's even/odd results,
//   aligns them, and writes both back to the two coefficient memory banks at their source addresses.
// - Carries each butterfly's addresses/flags through a delay line matching the butterfly latency.
// - Tracks in-flight butterflies, signals end of each NTT stage and end of the full transform.
// PARAMETERS
// - DATA_W    32  coefficient width; must equal the butterfly data width
// - ADDR_W    9   bank address width (N/2 words per bank)
// - BF_DELAY  7   butterfly input-to-EVEN latency (integer-mult delay + mod-reduction delay)
// - LOG_N     10  NTT stages per transform
// PORTS
// - clk          in   1       clock, rising edge
// - reset        in   1       asynchronous, active-high
// - in_valid     in   1       butterfly issued this cycle (same cycle its operands enter the butterfly)
// - in_addr_e    in   ADDR_W  bank-0 address of the even operand
// - in_addr_o    in   ADDR_W  bank-1 address of the odd operand
// - in_last      in   1       issued butterfly is the last of its stage
// - bf_even      in   DATA_W  butterfly even result (combinational, valid issue+BF_DELAY)
// - bf_odd       in   DATA_W  butterfly odd result (registered, valid issue+BF_DELAY+1)
// - wr_en        out  1       write strobe to both banks
// - wr_addr_e    out  ADDR_W  bank-0 write address
// - wr_addr_o    out  ADDR_W  bank-1 write address
// - wr_data_e    out  DATA_W  bank-0 write data
// - wr_data_o    out  DATA_W  bank-1 write data
// - inflight     out  4       butterflies issued but not yet written
// - busy         out  1       inflight!=0 or in_valid
// - stage_done   out  1       one-cycle pulse: last write of a stage completed
// - stage_idx    out  4       index of the stage currently being written back (0..LOG_N-1)
// - ntt_done     out  1       one-cycle pulse coincident with stage_done of stage LOG_N-1
// BEHAVIOUR
// - Reset (async): wr_en=0, wr_addr_*=0, wr_data_*=0, inflight=0, stage_done=0, stage_idx=0,
//   ntt_done=0; every delay-line valid bit cleared. Butterflies issued before reset are dropped.
// - Alignment: bf_even registered once -> even and odd both valid at issue+BF_DELAY+1.
// - Control delay line: {valid,addr_e,addr_o,last} delayed BF_DELAY+1 cycles, then output register.
// - Latency: in_valid at cycle t -> wr_en=1 at t+BF_DELAY+2 with that butterfly's addresses,
//   wr_data_e=bf_even(t+BF_DELAY), wr_data_o=bf_odd(t+BF_DELAY+1). Fixed; no backpressure.
// - Full throughput: one butterfly per cycle; back-to-back issues give back-to-back writes.
// - wr_addr_*/wr_data_* update only when a valid entry reaches the output; hold otherwise.
// - inflight: +1 on in_valid, -1 on wr_en, unchanged when both in same cycle; max BF_DELAY+2.
// - stage_done: asserted cycle after the write whose last flag=1. stage_idx increments on that
//   pulse; at LOG_N-1 it wraps to 0 and ntt_done pulses with stage_done.
// - in_last without in_valid is ignored. Consecutive last flags (1-butterfly stage) give
//   consecutive stage_done pulses.
// - Issuing next-stage reads is upstream's job; it must wait for stage_done (RAW hazard).
// STRUCTURE
// - Shared package: DATA_W, ADDR_W, BF_DELAY (= INTMUL_DELAY+MODRED_DELAY), LOG_N, and a
//   packed wb_ctrl_t {valid, addr_e, addr_o, last} struct.
// - One sub-module: ntt_ctrl_delay, parameterised-depth shift register of wb_ctrl_t with async
//   reset clearing only the valid bits (address/last fields need no reset).
// - Top: even-align register, output registers, inflight counter, stage counter, pulse logic.
// TESTING
// - Single issue t=0, addr_e=5, addr_o=6, bf_even=17@t7, bf_odd=23@t8 -> wr_en only @t9,
//   wr_addr_e=5, wr_addr_o=6, wr_data_e=17, wr_data_o=23; inflight 1 for t1..t9, 0 @t10.
// - 512 back-to-back issues, last on #512 -> 512 consecutive wr_en from t9, stage_done @t9+512,
//   stage_idx 0->1; inflight peaks at 9 and never exceeds it.
// - 10 stages of 512 with last each -> ten stage_done pulses, ntt_done with the 10th,
//   stage_idx returns to 0.
// - Alternating issue/idle -> wr_en alternates; inflight never changes on cycles with
//   simultaneous issue and write.
// - Reset asserted mid-stream with 4 in flight -> wr_en low immediately (async), no write of
//   dropped butterflies after release, inflight=0, stage_idx=0.
// - in_last=1 with in_valid=0 -> no stage_done, stage_idx unchanged.

Source files
------------

// File: rtl/ntt_bf_writeback_pkg.sv
// rtl/ntt_bf_writeback_pkg.sv - shared constants and control-word type for the butterfly writeback stage
// Purpose : widths, latencies and the per-butterfly control word carried alongside the datapath.
// Contents: DATA_W, ADDR_W, BF_DELAY (= INTMUL_DELAY + MODRED_DELAY), LOG_N, wb_ctrl_t, next_stage().
package ntt_bf_writeback_pkg;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 9;
  localparam int INTMUL_DELAY = 4;
  localparam int MODRED_DELAY = 3;
  localparam int BF_DELAY     = INTMUL_DELAY + MODRED_DELAY;
  localparam int LOG_N        = 10;

  // Control must line up with the odd result, which arrives one cycle after even.
  localparam int CTRL_DEPTH   = BF_DELAY + 1;
  localparam int INFL_W       = 4;
  localparam int STAGE_W      = 4;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr_e;
    logic [ADDR_W-1:0] addr_o;
    logic              last;
  } wb_ctrl_t;

  function automatic logic [STAGE_W-1:0] next_stage(input logic [STAGE_W-1:0] s);
    return (s == STAGE_W'(LOG_N - 1)) ? '0 : s + STAGE_W'(1);
  endfunction

endpackage

// File: rtl/ntt_ctrl_delay.sv
// rtl/ntt_ctrl_delay.sv - fixed-depth delay line for butterfly writeback control words
// Purpose : delays {valid, addr_e, addr_o, last} by DEPTH cycles.
// Ports   : clk, reset (async, active-high, clears valid bits only),
//           din (control word entering), dout (control word DEPTH cycles later).
import ntt_bf_writeback_pkg::*;

module ntt_ctrl_delay #(
  parameter int DEPTH = CTRL_DEPTH
) (
  input  logic     clk,
  input  logic     reset,
  input  wb_ctrl_t din,
  output wb_ctrl_t dout
);

  localparam int PL_W = 2 * ADDR_W + 1;

  logic [DEPTH-1:0] vld;
  logic [PL_W-1:0]  pl [DEPTH];

  // Only the valid bits need reset: a stale payload is never qualified.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
    end else begin
      vld <= {vld[DEPTH-2:0], din.valid};
    end
  end

  always_ff @(posedge clk) begin
    pl[0] <= {din.addr_e, din.addr_o, din.last};
    for (int i = 1; i < DEPTH; i++) begin
      pl[i] <= pl[i-1];
    end
  end

  always_comb begin
    dout.valid                      = vld[DEPTH-1];
    {dout.addr_e, dout.addr_o, dout.last} = pl[DEPTH-1];
  end

endmodule

// File: rtl/ntt_bf_writeback.sv
// rtl/ntt_bf_writeback.sv - aligns butterfly results and writes them back to both coefficient banks
// Purpose : even/odd alignment, write-port registers, in-flight tracking, stage/transform completion.
// Ports   : clk, reset (async, active-high);
//           in_valid/in_addr_e/in_addr_o/in_last - butterfly issue side;
//           bf_even (valid issue+BF_DELAY), bf_odd (valid issue+BF_DELAY+1) - butterfly results;
//           wr_en/wr_addr_e/wr_addr_o/wr_data_e/wr_data_o - bank write port (issue+BF_DELAY+2);
//           inflight, busy, stage_done, stage_idx, ntt_done - status.
import ntt_bf_writeback_pkg::*;

module ntt_bf_writeback (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [ADDR_W-1:0]  in_addr_e,
  input  logic [ADDR_W-1:0]  in_addr_o,
  input  logic               in_last,
  input  logic [DATA_W-1:0]  bf_even,
  input  logic [DATA_W-1:0]  bf_odd,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr_e,
  output logic [ADDR_W-1:0]  wr_addr_o,
  output logic [DATA_W-1:0]  wr_data_e,
  output logic [DATA_W-1:0]  wr_data_o,
  output logic [INFL_W-1:0]  inflight,
  output logic               busy,
  output logic               stage_done,
  output logic [STAGE_W-1:0] stage_idx,
  output logic               ntt_done
);

  wb_ctrl_t          ctrl_in;
  wb_ctrl_t          ctrl_out;
  logic [DATA_W-1:0] even_q;
  logic              wr_last;
  logic              last_write;

  // A last flag without a valid issue is meaningless; drop it at the door.
  always_comb begin
    ctrl_in.valid  = in_valid;
    ctrl_in.addr_e = in_addr_e;
    ctrl_in.addr_o = in_addr_o;
    ctrl_in.last   = in_valid & in_last;
  end

  ntt_ctrl_delay #(.DEPTH(CTRL_DEPTH)) u_ctrl_delay (
    .clk   (clk),
    .reset (reset),
    .din   (ctrl_in),
    .dout  (ctrl_out)
  );

  // Even is combinational out of the butterfly while odd is registered; one flop lines them up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      even_q <= '0;
    end else begin
      even_q <= bf_even;
    end
  end

  // Write port: address/data only move when a live entry arrives, otherwise they hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en     <= 1'b0;
      wr_addr_e <= '0;
      wr_addr_o <= '0;
      wr_data_e <= '0;
      wr_data_o <= '0;
      wr_last   <= 1'b0;
    end else begin
      wr_en <= ctrl_out.valid;
      if (ctrl_out.valid) begin
        wr_addr_e <= ctrl_out.addr_e;
        wr_addr_o <= ctrl_out.addr_o;
        wr_data_e <= even_q;
        wr_data_o <= bf_odd;
        wr_last   <= ctrl_out.last;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({in_valid, wr_en})
        2'b10:   inflight <= inflight + INFL_W'(1);
        2'b01:   inflight <= inflight - INFL_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign busy       = (inflight != '0) || in_valid;
  assign last_write = wr_en & wr_last;

  // stage_idx advances on the same edge that raises stage_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_done <= 1'b0;
      ntt_done   <= 1'b0;
      stage_idx  <= '0;
    end else begin
      stage_done <= last_write;
      ntt_done   <= last_write && (stage_idx == STAGE_W'(LOG_N - 1));
      if (last_write) begin
        stage_idx <= next_stage(stage_idx);
      end
    end
  end

endmodule

// File: tb/tb_ntt_bf_writeback.sv
// tb/tb_ntt_bf_writeback.sv - randomized self-checking bench for ntt_bf_writeback
module tb_ntt_bf_writeback;

  localparam int DW   = 32;
  localparam int AW   = 9;
  localparam int BFD  = 7;
  localparam int LAT  = BFD + 2;
  localparam int NST  = 10;
  localparam int MAXC = 5200;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [AW-1:0] in_addr_e = '0;
  logic [AW-1:0] in_addr_o = '0;
  logic          in_last = 1'b0;
  logic [DW-1:0] bf_even = '0;
  logic [DW-1:0] bf_odd = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr_e;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_e;
  logic [DW-1:0] wr_data_o;
  logic [3:0]    inflight;
  logic          busy;
  logic          stage_done;
  logic [3:0]    stage_idx;
  logic          ntt_done;

  ntt_bf_writeback dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_addr_e  (in_addr_e),
    .in_addr_o  (in_addr_o),
    .in_last    (in_last),
    .bf_even    (bf_even),
    .bf_odd     (bf_odd),
    .wr_en      (wr_en),
    .wr_addr_e  (wr_addr_e),
    .wr_addr_o  (wr_addr_o),
    .wr_data_e  (wr_data_e),
    .wr_data_o  (wr_data_o),
    .inflight   (inflight),
    .busy       (busy),
    .stage_done (stage_done),
    .stage_idx  (stage_idx),
    .ntt_done   (ntt_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit            iss_v    [MAXC];
  logic [AW-1:0] iss_ae   [MAXC];
  logic [AW-1:0] iss_ao   [MAXC];
  bit            iss_last [MAXC];
  bit            noise    [MAXC];
  logic [DW-1:0] ev       [MAXC];
  logic [DW-1:0] od       [MAXC];
  int            peak;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      iss_v[i] = 0; iss_last[i] = 0; noise[i] = 0;
      iss_ae[i] = '0; iss_ao[i] = '0; ev[i] = '0; od[i] = '0;
    end
  endtask

  task automatic put(input int c, input bit last);
    iss_v[c]    = 1;
    iss_ae[c]   = AW'($urandom);
    iss_ao[c]   = AW'($urandom);
    iss_last[c] = last;
    ev[c]       = $urandom;
    od[c]       = $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_addr", {wr_addr_e, wr_addr_o}, 0);
    check("rst_data_e", wr_data_e, 0);
    check("rst_data_o", wr_data_o, 0);
    check("rst_status", {inflight, stage_done, stage_idx, ntt_done}, 0);
    reset = 1'b0;
    @(posedge clk);
  endtask

  // Expectations come straight from issue history: a write lands LAT cycles after its issue,
  // the stage pulse one cycle after that, and in-flight is the issue count in the last LAT cycles.
  task automatic run_phase(input int ncyc);
    logic [AW-1:0] hae, hao;
    logic [DW-1:0] hde, hdo;
    int pulses, cnt;
    bit exp_wr, exp_sd, exp_nd;
    hae = '0; hao = '0; hde = '0; hdo = '0;
    pulses = 0;
    peak = 0;
    for (int c = 0; c < ncyc; c++) begin
      #1;
      in_valid  = iss_v[c];
      in_addr_e = iss_v[c] ? iss_ae[c] : AW'($urandom);
      in_addr_o = iss_v[c] ? iss_ao[c] : AW'($urandom);
      in_last   = iss_v[c] ? iss_last[c] : noise[c];
      bf_even   = $urandom;
      bf_odd    = $urandom;
      if (c >= BFD) begin
        if (iss_v[c-BFD]) bf_even = ev[c-BFD];
      end
      if (c >= BFD + 1) begin
        if (iss_v[c-BFD-1]) bf_odd = od[c-BFD-1];
      end
      @(negedge clk);
      exp_wr = 0;
      if (c >= LAT) exp_wr = iss_v[c-LAT];
      if (exp_wr) begin
        hae = iss_ae[c-LAT]; hao = iss_ao[c-LAT];
        hde = ev[c-LAT];     hdo = od[c-LAT];
      end
      cnt = 0;
      for (int j = c - LAT; j < c; j++) if (j >= 0 && iss_v[j]) cnt++;
      exp_sd = 0;
      if (c >= LAT + 1) exp_sd = iss_v[c-LAT-1] && iss_last[c-LAT-1];
      if (!exp_sd) check("stage_idx", stage_idx, pulses % NST);
      if (exp_sd) pulses++;
      exp_nd = exp_sd && (pulses % NST == 0);
      check("wr_en", wr_en, exp_wr);
      check("wr_addr_e", wr_addr_e, hae);
      check("wr_addr_o", wr_addr_o, hao);
      check("wr_data_e", wr_data_e, hde);
      check("wr_data_o", wr_data_o, hdo);
      check("inflight", inflight, cnt);
      check("busy", busy, (cnt != 0) || iss_v[c]);
      check("stage_done", stage_done, exp_sd);
      check("ntt_done", ntt_done, exp_nd);
      if (int'(inflight) > peak) peak = int'(inflight);
      @(posedge clk);
    end
  endtask

  initial begin
    // single butterfly with fixed values
    clear_stim();
    iss_v[0] = 1; iss_ae[0] = 5; iss_ao[0] = 6; ev[0] = 17; od[0] = 23;
    do_reset();
    run_phase(16);

    // one 512-butterfly stage back to back
    clear_stim();
    for (int i = 0; i < 512; i++) put(i, i == 511);
    do_reset();
    run_phase(512 + 16);
    check("peak_inflight", peak, LAT);

    // full transform: ten stages of 512
    clear_stim();
    for (int i = 0; i < 512 * NST; i++) put(i, (i % 512) == 511);
    do_reset();
    run_phase(512 * NST + 16);
    check("end_stage_idx", stage_idx, 0);

    // alternating issue/idle with occasional stage ends
    clear_stim();
    for (int i = 0; i < 200; i += 2) put(i, $urandom_range(0, 9) == 0);
    do_reset();
    run_phase(216);

    // random density, dense last flags (incl. back to back), stray last on idle cycles
    clear_stim();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 70) put(i, $urandom_range(0, 3) == 0);
      else noise[i] = 1;
    end
    do_reset();
    run_phase(316);

    // reset with four butterflies in flight
    clear_stim();
    for (int i = 0; i < 4; i++) put(i, i == 3);
    do_reset();
    run_phase(6);
    #2;
    reset = 1'b1;
    in_valid = 1'b0; in_last = 1'b0;
    #1;
    check("async_wr_en", wr_en, 0);
    check("async_inflight", inflight, 0);
    check("async_stage_idx", stage_idx, 0);
    clear_stim();
    do_reset();
    run_phase(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
